// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data access,
// one transaction at a time, with fetch anti-starvation, a watchdog and alignment checks.
module mem_port_arbiter #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_ack_o,
  output logic [31:0] if_rdata_o,
  output logic        if_err_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [3:0]  d_be_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic        d_ack_o,
  output logic [31:0] d_rdata_o,
  output logic        d_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int unsigned StarveW = $clog2(STARVE_MAX + 1);
  localparam int unsigned WdogW   = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e               state_q, state_d;
  logic                 data_own_q, data_own_d;
  logic [StarveW-1:0]   starve_q, starve_d;
  logic [WdogW-1:0]     wdog_q, wdog_d;
  logic                 mem_req_q, mem_req_d;
  logic                 mem_we_q, mem_we_d;
  logic [3:0]           mem_be_q, mem_be_d;
  logic [31:0]          mem_addr_q, mem_addr_d;
  logic [31:0]          mem_wdata_q, mem_wdata_d;
  logic                 if_ack_q, if_ack_d;
  logic [31:0]          if_rdata_q, if_rdata_d;
  logic                 if_err_q, if_err_d;
  logic                 d_ack_q, d_ack_d;
  logic [31:0]          d_rdata_q, d_rdata_d;
  logic                 d_err_q, d_err_d;
  logic                 timeout_c;
  logic                 unused_addr_bits;

  // Data addresses are word addresses; the low byte-offset bits carry no meaning.
  assign unused_addr_bits = ^d_addr_i[1:0];
  assign timeout_c        = (wdog_q == WdogW'(TIMEOUT - 1));

  // Next-state and output decode.
  always_comb begin
    state_d     = state_q;
    data_own_d  = data_own_q;
    starve_d    = starve_q;
    wdog_d      = wdog_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ack_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    if_err_d    = if_err_q;
    d_ack_d     = 1'b0;
    d_rdata_d   = d_rdata_q;
    d_err_d     = d_err_q;
    unique case (state_q)
      IDLE: begin
        if (d_req_i && (!if_req_i || (starve_q < StarveW'(STARVE_MAX)))) begin
          data_own_d = 1'b1;
          // Data can only win a tie below STARVE_MAX, so the increment never overflows.
          starve_d   = if_req_i ? starve_q + StarveW'(1) : '0;
          if (d_be_i == 4'h0) begin
            d_ack_d   = 1'b1;
            d_rdata_d = '0;
            d_err_d   = 1'b0;
            state_d   = RESP;
          end else begin
            mem_req_d   = 1'b1;
            mem_we_d    = d_we_i;
            mem_be_d    = d_be_i;
            mem_addr_d  = {d_addr_i[31:2], 2'b00};
            mem_wdata_d = d_wdata_i;
            wdog_d      = '0;
            state_d     = BUSY;
          end
        end else if (if_req_i) begin
          data_own_d = 1'b0;
          starve_d   = '0;
          if (if_addr_i[1:0] != 2'b00) begin
            if_ack_d   = 1'b1;
            if_rdata_d = '0;
            if_err_d   = 1'b1;
            state_d    = RESP;
          end else begin
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b0;
            mem_be_d    = 4'hF;
            mem_addr_d  = if_addr_i;
            mem_wdata_d = '0;
            wdog_d      = '0;
            state_d     = BUSY;
          end
        end
      end
      BUSY: begin
        // An ack in the watchdog's final cycle still completes cleanly.
        if (mem_ack_i || timeout_c) begin
          mem_req_d = 1'b0;
          state_d   = RESP;
          if (data_own_q) begin
            d_ack_d   = 1'b1;
            d_rdata_d = mem_ack_i ? mem_rdata_i : '0;
            d_err_d   = !mem_ack_i;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_ack_i ? mem_rdata_i : '0;
            if_err_d   = !mem_ack_i;
          end
        end else begin
          wdog_d = wdog_q + WdogW'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      data_own_q  <= 1'b0;
      starve_q    <= '0;
      wdog_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      if_err_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      d_rdata_q   <= '0;
      d_err_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_own_q  <= data_own_d;
      starve_q    <= starve_d;
      wdog_q      <= wdog_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      if_rdata_q  <= if_rdata_d;
      if_err_q    <= if_err_d;
      d_ack_q     <= d_ack_d;
      d_rdata_q   <= d_rdata_d;
      d_err_q     <= d_err_d;
    end
  end

  assign if_ack_o    = if_ack_q;
  assign if_rdata_o  = if_rdata_q;
  assign if_err_o    = if_err_q;
  assign d_ack_o     = d_ack_q;
  assign d_rdata_o   = d_rdata_q;
  assign d_err_o     = d_err_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_be_o    = mem_be_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule
